// File: rtl/rock_pkg.sv
// Shared types and default constants for the cradle rocking controller.
package rock_pkg;

    localparam int LEVEL_W = 3;
    localparam int HART_W  = 6;

    localparam int DEF_MAX_LEVEL      = 7;
    localparam int DEF_HIGH_HART      = 45;
    localparam int DEF_LOW_HART       = 25;
    localparam int DEF_HOLD_SAMPLES   = 4;
    localparam int DEF_SETTLE_SAMPLES = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        HOLD    = 3'd2,
        DOWN    = 3'd3,
        SETTLED = 3'd4
    } state_t;

endpackage

// File: rtl/hart_history.sv
// Three-deep heart-rate history with fill tracking and stability detect.
module hart_history
    import rock_pkg::*;
(
    input  logic              slow,
    input  logic              reset,
    input  logic              sample,
    input  logic [HART_W-1:0] hart,
    output logic              stable_now
);

    logic [HART_W-1:0] h1, h2, h3;
    logic [1:0]        fill;

    always_ff @(posedge slow or posedge reset) begin
        if (reset) begin
            h1   <= '0;
            h2   <= '0;
            h3   <= '0;
            fill <= '0;
        end else if (sample) begin
            h1 <= hart;
            h2 <= h1;
            h3 <= h2;
            if (fill != 2'd3)
                fill <= fill + 2'd1;
        end
    end

    // Incoming value plus all three stored values must agree.
    assign stable_now = sample && (fill == 2'd3) &&
                        (hart == h1) && (h1 == h2) && (h2 == h3);

endmodule

// File: rtl/rock_level_ctrl.sv
// Rocking-level state machine: ramps up on stress, holds, steps down when calm.
module rock_level_ctrl
    import rock_pkg::*;
#(
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int HIGH_HART      = DEF_HIGH_HART,
    parameter int LOW_HART       = DEF_LOW_HART,
    parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
    input  logic               slow,
    input  logic               reset,
    input  logic               enable,
    input  logic               sample,
    input  logic [HART_W-1:0]  hart,
    output logic [LEVEL_W-1:0] level,
    output logic               motor_on,
    output logic [2:0]         state,
    output logic               stable,
    output logic               calm
);

    localparam int HOLD_W   = $clog2(HOLD_SAMPLES) + 1;
    localparam int SETTLE_W = $clog2(SETTLE_SAMPLES) + 1;

    localparam logic [LEVEL_W-1:0]  LVL_MAX     = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0]  LVL_ONE     = LEVEL_W'(1);
    localparam logic [HART_W-1:0]   HI_TH       = HART_W'(HIGH_HART);
    localparam logic [HART_W-1:0]   LO_TH       = HART_W'(LOW_HART);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SAMPLES - 1);

    state_t               state_q, state_n;
    logic [LEVEL_W-1:0]   level_q, level_n;
    logic [HOLD_W-1:0]    hold_q, hold_n;
    logic [SETTLE_W-1:0]  settle_q, settle_n;
    logic                 calm_q, calm_n;
    logic                 motor_q, stable_q;
    logic                 stable_now;
    logic                 hi, lo, legal;
    logic [LEVEL_W-1:0]   level_up, level_dn;

    hart_history u_hist (
        .slow       (slow),
        .reset      (reset),
        .sample     (sample),
        .hart       (hart),
        .stable_now (stable_now)
    );

    assign hi       = (hart >= HI_TH);
    assign lo       = (hart <= LO_TH);
    assign legal    = state_q inside {IDLE, RAMP, HOLD, DOWN, SETTLED};
    assign level_up = (level_q >= LVL_MAX) ? LVL_MAX : level_q + LVL_ONE;
    assign level_dn = (level_q == '0) ? '0 : level_q - LVL_ONE;

    always_ff @(posedge slow or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            level_q  <= '0;
            hold_q   <= '0;
            settle_q <= '0;
            calm_q   <= 1'b0;
            motor_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            level_q  <= level_n;
            hold_q   <= hold_n;
            settle_q <= settle_n;
            calm_q   <= calm_n;
            motor_q  <= (level_n != '0);
            if (sample)
                stable_q <= stable_now;
        end
    end

    always_comb begin
        state_n  = state_q;
        level_n  = level_q;
        hold_n   = hold_q;
        settle_n = settle_q;
        calm_n   = 1'b0;
        if (!enable || !legal) begin
            state_n  = IDLE;
            level_n  = '0;
            hold_n   = '0;
            settle_n = '0;
        end else if (sample) begin
            case (state_q)
                IDLE: begin
                    if (hi) begin
                        level_n = LVL_ONE;
                        state_n = RAMP;
                    end
                end
                RAMP: begin
                    if (hi) begin
                        level_n = level_up;
                    end else begin
                        state_n = HOLD;
                        hold_n  = '0;
                    end
                end
                HOLD: begin
                    if (hi) begin
                        level_n = level_up;
                        state_n = RAMP;
                        hold_n  = '0;
                    end else if (stable_now && lo) begin
                        if (hold_q >= HOLD_LAST) begin
                            state_n = DOWN;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_q + 1'b1;
                        end
                    end else begin
                        hold_n = '0;
                    end
                end
                DOWN: begin
                    if (hi) begin
                        level_n = level_up;
                        state_n = RAMP;
                    end else begin
                        level_n = level_dn;
                        if (level_dn == '0) begin
                            state_n  = SETTLED;
                            settle_n = '0;
                            calm_n   = 1'b1;
                        end
                    end
                end
                SETTLED: begin
                    if (hi) begin
                        level_n  = LVL_ONE;
                        state_n  = RAMP;
                        settle_n = '0;
                    end else if (settle_q >= SETTLE_LAST) begin
                        state_n  = IDLE;
                        settle_n = '0;
                    end else begin
                        settle_n = settle_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign level    = level_q;
    assign motor_on = motor_q;
    assign state    = state_q;
    assign stable   = stable_q;
    assign calm     = calm_q;

endmodule

// File: doc/rock_level_ctrl.md
# rock_level_ctrl

Rocking-intensity controller for the cradle motor. It samples the 6-bit heart-rate value on a sample strobe and keeps a 3-deep history of it to detect a stable rate. A state machine ramps the rocking level up while the baby is stressed, holds it, and steps it down once the rate is low and stable. It sits between the heart-rate input path and the motor driver, all in the `slow` clock domain.

## Interface
Parameters:
- `MAX_LEVEL`, 7: highest rocking level; must be at most 7, since `level` is 3 bits.
- `HIGH_HART`, 45: a heart value greater than or equal to this means stressed.
- `LOW_HART`, 25: a heart value less than or equal to this counts as calm.
- `HOLD_SAMPLES`, 4: number of consecutive calm, stable samples needed before ramping down.
- `SETTLE_SAMPLES`, 6: number of samples spent in SETTLED before returning to IDLE.

Ports:
- `slow` in 1: the only clock; rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: controller enable.
- `sample` in 1: one-cycle strobe; `hart` is valid in the same cycle.
- `hart` in 6: heart-rate sample, unsigned.
- `level` out 3: current rocking level, 0 to `MAX_LEVEL`.
- `motor_on` out 1: high when `level` is not 0.
- `state` out 3: current FSM state encoding.
- `stable` out 1: registered copy of `stable_now`, updated on each sample.
- `calm` out 1: one-cycle pulse on entry to SETTLED.

## Operation
- History: on every `sample`, shift `hart` → h1 → h2 → h3. This happens regardless of `enable`.
  - A fill counter saturates at 3.
- `stable_now` = `sample` AND fill==3 AND `hart`==h1 AND h1==h2 AND h2==h3. It uses the incoming value together with the three stored values.
- "hi" means `hart` ≥ `HIGH_HART`.
- The FSM advances only in cycles where `sample`=1 and `enable`=1. In all other cycles every register holds, except the history and the disable behaviour below.
- IDLE (0): on hi, set `level`=1 and go to RAMP. Otherwise stay.
- RAMP (1):
  - On hi, `level` increments, saturating at `MAX_LEVEL`; stay in RAMP.
  - On not hi, go to HOLD and set hold_cnt=0.
- HOLD (2):
  - On hi, `level` increments (saturating) and the FSM goes to RAMP.
  - On `stable_now` AND `hart` ≤ `LOW_HART`, hold_cnt increments. If hold_cnt was `HOLD_SAMPLES`-1, go to DOWN instead.
  - On any other sample, clear hold_cnt.
- DOWN (3):
  - On hi, `level` increments and the FSM goes to RAMP.
  - Otherwise `level` decrements. If the result is 0, go to SETTLED and pulse `calm`.
- SETTLED (4):
  - On hi, set `level`=1 and go to RAMP.
  - Otherwise settle_cnt increments. At `SETTLE_SAMPLES`-1, go to IDLE and clear settle_cnt.
- Priority: hi overrides every other condition in every state.
- `enable` low: in the next clock, go to IDLE and clear `level`, hold_cnt and settle_cnt. `calm` stays 0 and the history keeps shifting.
- Width rules:
  - `level` never wraps past `MAX_LEVEL` and never drops below 0.
  - hold_cnt and settle_cnt are sized `$clog2` of their parameter plus 1, and must not wrap.
- Encodings 5–7 are illegal and recover to IDLE with `level`=0.

## Timing
- All outputs are registered and change on the `slow` edge that samples `sample`=1. Latency is one clock from strobe to new `level`.
- Reset values: `level`=0, `motor_on`=0, `state`=IDLE, `stable`=0, `calm`=0, history=0, fill=0, all counters=0.
- `calm` is high for exactly one clock.
- Reset asserted mid-ramp clears everything immediately and asynchronously. The first sample after reset release starts a fresh fill.
- Back-to-back strobes (`sample` high every clock) are legal; each one is processed.

## Structure
- Package `rock_pkg`:
  - the state enum, with IDLE=0, RAMP=1, HOLD=2, DOWN=3, SETTLED=4;
  - the default threshold constants;
  - the level width constant of 3.
- Sub-module `hart_history`: the 3-stage shift register gated by `sample`, the fill counter, and `stable_now`.
- `rock_level_ctrl` contains the FSM, the level register and the counters.

## Test plan
- Reset, then `enable`=1 and samples 50, 50, 50 → `level` goes 1, 2, 3 with RAMP, then HOLD on a sample of 30.
- From HOLD at `level`=3, samples of 20 ×7 → hold_cnt reaches the threshold at the 7th (fill plus stability) → DOWN. Then samples of 20 ×3 → `level` goes 2, 1, 0, `calm` pulses once, state is SETTLED.
- Nine samples of 60 → `level` saturates at 7, stays in RAMP, no wrap.
- In HOLD, calm samples 20, 20, 20, 20, 21, 20 → hold_cnt clears on the 21 and the FSM does not enter DOWN early.
- In DOWN at `level`=2, a sample of 45 → `level`=3 and state RAMP (the boundary value counts as hi).
- `enable` dropped in RAMP at `level`=4 → IDLE with `level`=0 next clock. Separately, `reset` pulsed mid-DOWN → all outputs 0 asynchronously.
